// File: rtl/note_scheduler_pkg.sv
// Shared types and tables for the note scheduler: FSM states, note codes,
// song length and the tone frequency tables that the divider ROM is built from.
package note_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SONG   = 2'd1,
      MANUAL = 2'd2
   } state_e;

   localparam logic [2:0]  NOTE_NONE  = 3'd7;
   localparam int unsigned NOTE_COUNT = 7;
   localparam int unsigned SONG_LEN   = 11;

   // Manual notes A..G in Hz
   localparam int unsigned MAN_FREQ [NOTE_COUNT] = '{220, 247, 261, 294, 330, 349, 392};

   // Song melody, one frequency per step, in Hz
   localparam int unsigned SONG_FREQ [SONG_LEN] =
      '{277, 554, 415, 370, 740, 415, 698, 415, 311, 370, 277};

   // Half-period in clock cycles for a square wave at freqHz
   function automatic logic [31:0] halfPeriod(input int unsigned clkHz, input int unsigned freqHz);
      return 32'(clkHz / (2 * freqHz));
   endfunction

endpackage

// File: rtl/note_div_rom.sv
// Combinational divider lookup shared by song playback and manual strums.
// The tables are elaborated to constants, so no runtime divider is built.
module note_div_rom
   import note_scheduler_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000
) (
   input  logic        manSel_i,
   input  logic [3:0]  index_i,
   output logic [31:0] div_o
);

   logic [31:0] manTable  [8];
   logic [31:0] songTable [16];

   for (genvar i = 0; i < 8; i++) begin : gMan
      if (i < NOTE_COUNT) begin : gNote
         assign manTable[i] = halfPeriod(CLK_HZ, MAN_FREQ[i]);
      end else begin : gNone
         assign manTable[i] = '0;
      end
   end

   for (genvar i = 0; i < 16; i++) begin : gSong
      if (i < SONG_LEN) begin : gStep
         assign songTable[i] = halfPeriod(CLK_HZ, SONG_FREQ[i]);
      end else begin : gUnused
         assign songTable[i] = '0;
      end
   end

   // Pick the manual table when a strum is being served, else the song table
   always_comb begin
      div_o = '0;
      if (manSel_i) begin
         div_o = manTable[index_i[2:0]];
      end else begin
         div_o = songTable[index_i];
      end
   end

endmodule

// File: rtl/note_scheduler.sv
// Arbitrates the tone generator between a looping song and manual strums.
// A strum preempts the song; the song's step and note counter freeze while
// the manual note is held and resume where they left off afterwards.
module note_scheduler
   import note_scheduler_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned NOTE_TICKS = 12500000,
   parameter int unsigned HOLD_TICKS = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        play_toggle,
   input  logic        strum,
   input  logic [2:0]  note_sel,
   output logic [31:0] divider,
   output logic        tone_en,
   output logic        grant_manual,
   output logic        song_active,
   output logic [3:0]  step
);

   state_e      state_q, state_d;
   logic        songActive_q, songActive_d;
   logic [3:0]  step_q, step_d;
   logic [31:0] noteCnt_q, noteCnt_d;
   logic [31:0] holdCnt_q, holdCnt_d;
   logic [31:0] divider_q, divider_d;
   logic        toneEn_q, toneEn_d;
   logic        grantManual_q, grantManual_d;

   logic        strumGo;
   logic        strumEnd;
   logic [3:0]  romIndex;
   logic [31:0] romDiv;

   assign strumGo  = strum && (note_sel != NOTE_NONE);
   assign strumEnd = strum && (note_sel == NOTE_NONE) && (state_q == MANUAL);
   assign romIndex = strumGo ? {1'b0, note_sel} : step_d;

   note_div_rom #(
      .CLK_HZ (CLK_HZ)
   ) uRom (
      .manSel_i (strumGo),
      .index_i  (romIndex),
      .div_o    (romDiv)
   );

   // Next state: the play toggle is applied first, then a strum decides the final state
   always_comb begin
      state_d      = state_q;
      songActive_d = songActive_q;
      step_d       = step_q;
      noteCnt_d    = noteCnt_q;
      holdCnt_d    = holdCnt_q;

      unique case (state_q)
         IDLE: begin
            if (play_toggle) begin
               state_d      = SONG;
               songActive_d = 1'b1;
               step_d       = '0;
               noteCnt_d    = '0;
            end
         end
         SONG: begin
            if (play_toggle) begin
               state_d      = IDLE;
               songActive_d = 1'b0;
               step_d       = '0;
               noteCnt_d    = '0;
            end else if (!strumGo) begin
               if (noteCnt_q == NOTE_TICKS - 1) begin
                  noteCnt_d = '0;
                  step_d    = (step_q == 4'(SONG_LEN - 1)) ? 4'd0 : step_q + 4'd1;
               end else begin
                  noteCnt_d = noteCnt_q + 32'd1;
               end
            end
         end
         MANUAL: begin
            if (play_toggle) begin
               songActive_d = !songActive_q;
               if (songActive_q) begin
                  step_d    = '0;
                  noteCnt_d = '0;
               end
            end
            if (holdCnt_q == '0) begin
               state_d   = songActive_d ? SONG : IDLE;
               holdCnt_d = '0;
            end else begin
               holdCnt_d = holdCnt_q - 32'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (strumGo) begin
         state_d   = MANUAL;
         holdCnt_d = HOLD_TICKS - 1;
      end else if (strumEnd) begin
         state_d   = songActive_d ? SONG : IDLE;
         holdCnt_d = '0;
      end
   end

   // Output values for the next cycle, derived from the state being entered
   always_comb begin
      divider_d     = '0;
      toneEn_d      = (state_d != IDLE);
      grantManual_d = (state_d == MANUAL);
      unique case (state_d)
         IDLE:    divider_d = '0;
         SONG:    divider_d = romDiv;
         MANUAL:  divider_d = strumGo ? romDiv : divider_q;
         default: divider_d = '0;
      endcase
   end

   // State and output registers; reset abandons any note in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         songActive_q  <= 1'b0;
         step_q        <= '0;
         noteCnt_q     <= '0;
         holdCnt_q     <= '0;
         divider_q     <= '0;
         toneEn_q      <= 1'b0;
         grantManual_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         songActive_q  <= songActive_d;
         step_q        <= step_d;
         noteCnt_q     <= noteCnt_d;
         holdCnt_q     <= holdCnt_d;
         divider_q     <= divider_d;
         toneEn_q      <= toneEn_d;
         grantManual_q <= grantManual_d;
      end
   end

   assign divider      = divider_q;
   assign tone_en      = toneEn_q;
   assign grant_manual = grantManual_q;
   assign song_active  = songActive_q;
   assign step         = step_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler with short song steps and hold times.
// Stimulus pushes the hand-computed outputs expected after each edge; a
// monitor on the falling edge pops and compares them.
module tb_note_scheduler;

   localparam int unsigned SONG_EXP [11] =
      '{90252, 45126, 60240, 67567, 33783, 60240, 35816, 60240, 80385, 67567, 90252};

   typedef struct packed {
      logic [31:0] due;
      logic [31:0] div;
      logic        tone;
      logic        grant;
      logic        active;
      logic [3:0]  step;
   } expect_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        playToggle = 1'b0;
   logic        strum = 1'b0;
   logic [2:0]  noteSel = 3'd7;
   logic [31:0] divider;
   logic        toneEn;
   logic        grantManual;
   logic        songActive;
   logic [3:0]  step;

   expect_t sb[$];
   string   nameSb[$];
   int      cyc = 0;
   int      errors = 0;
   int      checks = 0;

   note_scheduler #(
      .CLK_HZ     (50000000),
      .NOTE_TICKS (4),
      .HOLD_TICKS (6)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .play_toggle  (playToggle),
      .strum        (strum),
      .note_sel     (noteSel),
      .divider      (divider),
      .tone_en      (toneEn),
      .grant_manual (grantManual),
      .song_active  (songActive),
      .step         (step)
   );

   // Free-running clock and edge counter used to time-stamp expectations
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic applyStimulus(input logic rst, input logic tog, input logic str,
                                input logic [2:0] sel, input logic [31:0] eDiv,
                                input logic eTone, input logic eGrant, input logic eActive,
                                input logic [3:0] eStep, input string name);
      expect_t e;
      @(posedge clk);
      #1;
      reset      = rst;
      playToggle = tog;
      strum      = str;
      noteSel    = sel;
      e.due      = 32'(cyc + 1);
      e.div      = eDiv;
      e.tone     = eTone;
      e.grant    = eGrant;
      e.active   = eActive;
      e.step     = eStep;
      sb.push_back(e);
      nameSb.push_back(name);
   endtask

   task automatic idleCycle(input logic rst, input logic tog, input logic str,
                            input logic [2:0] sel, input string name);
      applyStimulus(rst, tog, str, sel, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, name);
   endtask

   task automatic songCycle(input logic tog, input logic str, input logic [2:0] sel,
                            input int stp, input string name);
      applyStimulus(1'b0, tog, str, sel, 32'(SONG_EXP[stp]), 1'b1, 1'b0, 1'b1, 4'(stp), name);
   endtask

   task automatic manCycle(input logic tog, input logic str, input logic [2:0] sel,
                           input logic [31:0] div, input logic active, input int stp,
                           input string name);
      applyStimulus(1'b0, tog, str, sel, div, 1'b1, 1'b1, active, 4'(stp), name);
   endtask

   // Pop the oldest expectation and compare it against the live outputs
   task automatic checkOutput();
      expect_t e;
      string   name;
      e    = sb.pop_front();
      name = nameSb.pop_front();
      checks++;
      if (int'(e.due) != cyc) begin
         errors++;
         $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", name, cyc, e.due);
      end else if ({divider, toneEn, grantManual, songActive, step} !==
                   {e.div, e.tone, e.grant, e.active, e.step}) begin
         errors++;
         $display("[TB] FAIL %s: got div=%0d tone=%0b grant=%0b active=%0b step=%0d, want div=%0d tone=%0b grant=%0b active=%0b step=%0d",
                  name, divider, toneEn, grantManual, songActive, step,
                  e.div, e.tone, e.grant, e.active, e.step);
      end
   endtask

   // Monitor: compare on the falling edge, away from the sampling edge
   always @(negedge clk) begin
      if (sb.size() > 0 && int'(sb[0].due) <= cyc) begin
         checkOutput();
      end
   end

   // Hard time limit so the bench always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      // Reset holds everything at zero and ignores inputs
      idleCycle(1'b1, 1'b0, 1'b0, 3'd7, "reset0");
      idleCycle(1'b1, 1'b1, 1'b1, 3'd3, "resetIgnoresInputs");
      idleCycle(1'b0, 1'b0, 1'b0, 3'd7, "afterReset");
      idleCycle(1'b0, 1'b0, 1'b1, 3'd7, "strumNoneIdle");

      // Start the song, run past the wrap, stop on a step boundary
      songCycle(1'b1, 1'b0, 3'd7, 0, "playStart");
      for (int n = 1; n <= 47; n++) songCycle(1'b0, 1'b0, 3'd7, (n / 4) % 11, "songRun");
      idleCycle(1'b0, 1'b1, 1'b0, 3'd7, "stopAtBoundary");

      // Preempt at step 2 count 1 and resume at the same point
      songCycle(1'b1, 1'b0, 3'd7, 0, "playAgain");
      for (int n = 1; n <= 9; n++) songCycle(1'b0, 1'b0, 3'd7, n / 4, "toStep2");
      manCycle(1'b0, 1'b1, 3'd0, 32'd113636, 1'b1, 2, "strumA");
      for (int i = 0; i < 5; i++) manCycle(1'b0, 1'b0, 3'd7, 32'd113636, 1'b1, 2, "holdA");
      songCycle(1'b0, 1'b0, 3'd7, 2, "resumeStep2");
      for (int i = 0; i < 2; i++) songCycle(1'b0, 1'b0, 3'd7, 2, "resumeCount");
      songCycle(1'b0, 1'b0, 3'd7, 3, "resumeAdvance");
      idleCycle(1'b0, 1'b1, 1'b0, 3'd7, "stopC");

      // Manual note from idle, cancelled by a none-strum
      manCycle(1'b0, 1'b1, 3'd6, 32'd63775, 1'b0, 0, "strumG");
      manCycle(1'b0, 1'b0, 3'd7, 32'd63775, 1'b0, 0, "holdG");
      idleCycle(1'b0, 1'b0, 1'b1, 3'd7, "strumNoneEnds");

      // A strum on the expiry cycle wins and reloads the hold
      manCycle(1'b0, 1'b1, 3'd5, 32'd71633, 1'b0, 0, "strumF");
      for (int i = 0; i < 5; i++) manCycle(1'b0, 1'b0, 3'd7, 32'd71633, 1'b0, 0, "holdF");
      manCycle(1'b0, 1'b1, 3'd0, 32'd113636, 1'b0, 0, "strumBeatsExpiry");
      manCycle(1'b0, 1'b0, 3'd7, 32'd113636, 1'b0, 0, "reloaded");
      idleCycle(1'b0, 1'b0, 1'b1, 3'd7, "strumNoneEndsH");

      // Toggle and strum together from idle, then fall back to the song
      manCycle(1'b1, 1'b1, 3'd3, 32'd85034, 1'b1, 0, "toggleAndStrum");
      for (int i = 0; i < 5; i++) manCycle(1'b0, 1'b0, 3'd7, 32'd85034, 1'b1, 0, "holdD");
      songCycle(1'b0, 1'b0, 3'd7, 0, "resumeStep0");
      for (int i = 0; i < 3; i++) songCycle(1'b0, 1'b0, 3'd7, 0, "resumeStep0Count");
      songCycle(1'b0, 1'b0, 3'd7, 1, "advanceAfterResume");

      // Re-strum inside manual, then switch playback off while held
      manCycle(1'b0, 1'b1, 3'd1, 32'd101214, 1'b1, 1, "strumB");
      for (int i = 0; i < 2; i++) manCycle(1'b0, 1'b0, 3'd7, 32'd101214, 1'b1, 1, "holdB");
      manCycle(1'b0, 1'b1, 3'd4, 32'd75757, 1'b1, 1, "restrumE");
      manCycle(1'b1, 1'b0, 3'd7, 32'd75757, 1'b0, 0, "toggleOffInManual");
      for (int i = 0; i < 4; i++) manCycle(1'b0, 1'b0, 3'd7, 32'd75757, 1'b0, 0, "holdE");
      idleCycle(1'b0, 1'b0, 1'b0, 3'd7, "expireToIdle");

      // Reset in the middle of a hold leaves nothing behind
      songCycle(1'b1, 1'b0, 3'd7, 0, "playG");
      manCycle(1'b0, 1'b1, 3'd2, 32'd95785, 1'b1, 0, "strumC");
      for (int i = 0; i < 2; i++) manCycle(1'b0, 1'b0, 3'd7, 32'd95785, 1'b1, 0, "holdC");
      idleCycle(1'b1, 1'b0, 1'b0, 3'd7, "resetMidHold");
      for (int i = 0; i < 6; i++) idleCycle(1'b0, 1'b0, 1'b0, 3'd7, "noResidual");
      songCycle(1'b1, 1'b0, 3'd7, 0, "restart");
      songCycle(1'b0, 1'b0, 3'd7, 0, "restartCount");
      idleCycle(1'b0, 1'b1, 1'b0, 3'd7, "stopG");
      idleCycle(1'b0, 1'b0, 1'b0, 3'd7, "final");

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter NOTE_TICKS, default 12500000, meaning the clock cycles per song step.
REQ-003 The block SHALL have parameter HOLD_TICKS, default 25000000, meaning the clock cycles a manual note is held.
REQ-004 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port play_toggle, input, 1 bit: single-cycle pulse that starts or stops song playback.
REQ-007 Port strum, input, 1 bit: single-cycle pulse for a manual strum request.
REQ-008 Port note_sel, input, 3 bits: manual note code, 0..6 = A..G and 7 = none; sampled only on strum.
REQ-009 Port divider, output, 32 bits: half-period count for the downstream square-wave generator; 0 when silent.
REQ-010 Port tone_en, output, 1 bit: high while a note is granted.
REQ-011 Port grant_manual, output, 1 bit: high while the manual requester owns the tone generator.
REQ-012 Port song_active, output, 1 bit: high while song playback is enabled, including while preempted.
REQ-013 Port step, output, 4 bits: current song step index.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SONG and MANUAL.
REQ-015 All outputs SHALL be registered and SHALL reflect a qualifying input pulse on the cycle after that pulse.
REQ-016 In IDLE, play_toggle SHALL go to SONG with song_active=1, step=0, note counter=0 and divider=SONG_DIV[0].
REQ-017 In SONG, the note counter SHALL increment every cycle; at NOTE_TICKS-1 it SHALL clear and step SHALL advance.
REQ-018 Step advance SHALL wrap from SONG_LEN-1 to 0, and divider SHALL become SONG_DIV[new step] on the same edge.
REQ-019 In SONG, play_toggle SHALL go to IDLE with song_active=0 and step=0; a stop SHALL take priority over a same-cycle step boundary.
REQ-020 A strum with note_sel≠7 in any state SHALL go to MANUAL with grant_manual=1, divider=MAN_DIV[note_sel] and hold counter=HOLD_TICKS-1.
REQ-021 A strum with note_sel≠7 while already in MANUAL SHALL reload the hold counter and update divider.
REQ-022 A strum with note_sel=7 SHALL end MANUAL immediately and SHALL be ignored in IDLE and SONG.
REQ-023 In MANUAL, the hold counter SHALL decrement every cycle; at 0 the block SHALL return to SONG if song_active=1, otherwise to IDLE.
REQ-024 A strum SHALL take priority over a same-cycle hold expiry.
REQ-025 During MANUAL, the song note counter and step SHALL freeze.
REQ-026 On return to SONG, the song SHALL resume at the frozen step and count, with divider=SONG_DIV[step].
REQ-027 In MANUAL, play_toggle SHALL only toggle song_active; turning playback off SHALL also zero step and the note counter.
REQ-028 When play_toggle and strum occur in the same cycle, the toggle SHALL be applied first and the strum SHALL then decide the state.
REQ-029 In IDLE, the block SHALL drive tone_en=0 and divider=0; in SONG and MANUAL it SHALL drive tone_en=1.
REQ-030 MAN_DIV[i] SHALL equal CLK_HZ/(2*f_i) with integer truncation, for f = 220, 247, 261, 294, 330, 349, 392 Hz.
REQ-031 SONG_DIV[k] SHALL equal CLK_HZ/(2*s_k), for the 11-step s = 277, 554, 415, 370, 740, 415, 698, 415, 311, 370, 277 Hz.

Reset
REQ-032 While reset=1, the block SHALL enter IDLE with every output and counter at 0, ignoring all inputs in that cycle.
REQ-033 A reset mid-note or mid-hold SHALL abandon the note with no residual state.

Structure
REQ-034 A shared package SHALL hold the state enum, note-code constants (NOTE_NONE=7), SONG_LEN=11, and both frequency tables.
REQ-035 Divider lookup SHALL be one combinational sub-module, note_div_rom, selected by a table-select flag plus an index.

Verification (NOTE_TICKS=4, HOLD_TICKS=6, CLK_HZ=50000000)
REQ-036 Pulse play_toggle -> next cycle tone_en=1, step=0, divider=90252; step=1 and divider=45126 after 4 more cycles.
REQ-037 Run the song through 11 steps -> step wraps 10 to 0 and divider returns to 90252.
REQ-038 In SONG at step 2, count 1, strum note_sel=0 -> grant_manual=1 and divider=113636 for 6 cycles, then resume at step 2, count 1.
REQ-039 Strum note_sel=6 in IDLE, then strum note_sel=7 two cycles later -> divider=63775, then IDLE with divider=0.
REQ-040 play_toggle and strum note_sel=3 in the same cycle from IDLE -> MANUAL with song_active=1, divider=85034, then SONG at step 0.
REQ-041 Assert reset mid-hold -> next cycle all outputs 0; a later play_toggle restarts at step 0.
